// File: rtl/bob_except_banked_pkg.sv
// Shared definitions for the banked reorder-buffer exception store.
package bob_except_banked_pkg;

  // Width of one exception record.
  localparam int except_width = 8;

  // Default geometry of the store.
  localparam int BOB_NBANK  = 10;
  localparam int BOB_NROW   = 64;
  localparam int BOB_WPORTS = 9;

  localparam int BOB_BW = $clog2(BOB_NBANK);
  localparam int BOB_RW = $clog2(BOB_NROW);

  // One writeback address at the default geometry: {row, bank}.
  typedef struct packed {
    logic [BOB_RW-1:0] row;
    logic [BOB_BW-1:0] bank;
  } bob_addr_t;

endpackage

// File: rtl/bob_except_bank_ram.sv
// One bank of exception records: NROW x DATA_WIDTH storage with NPORT write
// ports (the highest-numbered enabled port wins on a shared row) and a
// registered read that captures the contents as they were before this
// cycle's writes.
module bob_except_bank_ram
  import bob_except_banked_pkg::*;
#(
  parameter int DATA_WIDTH = except_width,
  parameter int NROW       = BOB_NROW,
  parameter int NPORT      = BOB_WPORTS + 1,
  parameter int RW         = $clog2(NROW)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            we,
  input  logic [NPORT*RW-1:0]         waddr,
  input  logic [NPORT*DATA_WIDTH-1:0] wdata,
  input  logic                        re,
  input  logic [RW-1:0]               raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);

  logic [DATA_WIDTH-1:0] mem [NROW];

  // Storage writes; later ports overwrite earlier ones, so the highest wins.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (we[p]) begin
        mem[waddr[p*RW +: RW]] <= wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read register: samples pre-write contents, holds when not reading.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bob_except_banked.sv
// Banked exception store between execute writeback and retire. Per-cell valid
// bits, row clear-on-retire, global flush, lowest-bank priority select and
// sticky error flags for write collisions and out-of-range bank indices.
module bob_except_banked
  import bob_except_banked_pkg::*;
#(
  parameter int DATA_WIDTH = except_width,
  parameter int NBANK      = BOB_NBANK,
  parameter int NROW       = BOB_NROW,
  parameter int WPORTS     = BOB_WPORTS,
  parameter int BW         = $clog2(NBANK),
  parameter int RW         = $clog2(NROW)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WPORTS-1:0]            wr_wen,
  input  logic [WPORTS*(RW+BW)-1:0]    wr_addr,
  input  logic [WPORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                         init_wen,
  input  logic [RW-1:0]                init_row,
  input  logic [NBANK-1:0]             init_mask,
  input  logic [NBANK*DATA_WIDTH-1:0]  init_data,
  input  logic                         flush,
  input  logic                         rd_req,
  input  logic [RW-1:0]                rd_row,
  input  logic                         rd_clear,
  output logic                         rd_valid,
  output logic [NBANK*DATA_WIDTH-1:0]  rd_data,
  output logic [NBANK-1:0]             rd_vmask,
  output logic                         rd_any,
  output logic [BW-1:0]                rd_first,
  output logic                         err_collide,
  output logic                         err_badbank
);

  localparam int NPORT = WPORTS + 1;

  logic [RW-1:0]    port_row  [WPORTS];
  logic [BW-1:0]    port_bank [WPORTS];
  logic [WPORTS-1:0] port_ok;
  logic             any_badbank;
  logic             any_collide;
  logic [NBANK-1:0] valid_q [NROW];
  logic [NBANK-1:0] rd_mask_now;
  logic [BW-1:0]    first_now;

  // Split each port address into row/bank and qualify with the bank range.
  always_comb begin
    any_badbank = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      port_row[p]  = wr_addr[p*(RW+BW)+BW +: RW];
      port_bank[p] = wr_addr[p*(RW+BW) +: BW];
      port_ok[p]   = wr_wen[p] && (int'(port_bank[p]) < NBANK);
      if (wr_wen[p] && (int'(port_bank[p]) >= NBANK)) begin
        any_badbank = 1'b1;
      end
    end
  end

  // Two in-range enabled ports on the same cell is a collision.
  always_comb begin
    any_collide = 1'b0;
    for (int p = 0; p < WPORTS; p++) begin
      for (int q = p + 1; q < WPORTS; q++) begin
        if (port_ok[p] && port_ok[q] &&
            port_row[p] == port_row[q] && port_bank[p] == port_bank[q]) begin
          any_collide = 1'b1;
        end
      end
    end
  end

  // Per-bank storage; init is port 0 so every writeback port overrides it.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [NPORT-1:0]            b_we;
    logic [NPORT*RW-1:0]         b_waddr;
    logic [NPORT*DATA_WIDTH-1:0] b_wdata;

    // Gather this bank's write ports.
    always_comb begin
      b_we[0]                  = init_wen;
      b_waddr[RW-1:0]          = init_row;
      b_wdata[DATA_WIDTH-1:0]  = init_data[b*DATA_WIDTH +: DATA_WIDTH];
      for (int p = 0; p < WPORTS; p++) begin
        b_we[p+1]                                = port_ok[p] && (port_bank[p] == BW'(b));
        b_waddr[(p+1)*RW +: RW]                  = port_row[p];
        b_wdata[(p+1)*DATA_WIDTH +: DATA_WIDTH]  = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    bob_except_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .NROW       (NROW),
      .NPORT      (NPORT),
      .RW         (RW)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (b_we),
      .waddr (b_waddr),
      .wdata (b_wdata),
      .re    (rd_req),
      .raddr (rd_row),
      .rdata (rd_data[b*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Valid bits: clear-on-retire, then init, then port writes, flush last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NROW; r++) begin
        valid_q[r] <= '0;
      end
    end else begin
      if (rd_req && rd_clear) begin
        valid_q[rd_row] <= '0;
      end
      if (init_wen) begin
        valid_q[init_row] <= init_mask;
      end
      for (int p = 0; p < WPORTS; p++) begin
        if (port_ok[p]) begin
          valid_q[port_row[p]][port_bank[p]] <= 1'b1;
        end
      end
      if (flush) begin
        for (int r = 0; r < NROW; r++) begin
          valid_q[r] <= '0;
        end
      end
    end
  end

  // Lowest-index valid bank of the row being read.
  always_comb begin
    rd_mask_now = valid_q[rd_row];
    first_now   = '0;
    for (int b = NBANK - 1; b >= 0; b--) begin
      if (rd_mask_now[b]) begin
        first_now = BW'(b);
      end
    end
  end

  // Read-side output registers; hold when no request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_vmask <= '0;
      rd_any   <= 1'b0;
      rd_first <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_vmask <= rd_mask_now;
        rd_any   <= |rd_mask_now;
        rd_first <= first_now;
      end
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_collide <= 1'b0;
      err_badbank <= 1'b0;
    end else begin
      if (any_collide) err_collide <= 1'b1;
      if (any_badbank) err_badbank <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bob_except_banked.sv
// Directed bench for bob_except_banked at its default geometry.
module tb_bob_except_banked;
  import bob_except_banked_pkg::*;

  localparam int DW = except_width;
  localparam int NB = BOB_NBANK;
  localparam int NR = BOB_NROW;
  localparam int WP = BOB_WPORTS;
  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(NR);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WP-1:0]        wr_wen;
  logic [WP*(RW+BW)-1:0] wr_addr;
  logic [WP*DW-1:0]     wr_data;
  logic                 init_wen;
  logic [RW-1:0]        init_row;
  logic [NB-1:0]        init_mask;
  logic [NB*DW-1:0]     init_data;
  logic                 flush;
  logic                 rd_req;
  logic [RW-1:0]        rd_row;
  logic                 rd_clear;
  logic                 rd_valid;
  logic [NB*DW-1:0]     rd_data;
  logic [NB-1:0]        rd_vmask;
  logic                 rd_any;
  logic [BW-1:0]        rd_first;
  logic                 err_collide;
  logic                 err_badbank;

  int checks = 0;
  int errors = 0;

  bob_except_banked dut (
    .clk         (clk),
    .rst         (rst),
    .wr_wen      (wr_wen),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .init_wen    (init_wen),
    .init_row    (init_row),
    .init_mask   (init_mask),
    .init_data   (init_data),
    .flush       (flush),
    .rd_req      (rd_req),
    .rd_row      (rd_row),
    .rd_clear    (rd_clear),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_vmask    (rd_vmask),
    .rd_any      (rd_any),
    .rd_first    (rd_first),
    .err_collide (err_collide),
    .err_badbank (err_badbank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_wen    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    init_wen  = 1'b0;
    init_row  = '0;
    init_mask = '0;
    init_data = '0;
    flush     = 1'b0;
    rd_req    = 1'b0;
    rd_row    = '0;
    rd_clear  = 1'b0;
  endtask

  task automatic port_wr(input int p, input int row, input int bank, input logic [DW-1:0] d);
    bob_addr_t a;
    a.row  = RW'(row);
    a.bank = BW'(bank);
    wr_wen[p]              = 1'b1;
    wr_addr[p*(RW+BW) +: RW+BW] = a;
    wr_data[p*DW +: DW]    = d;
  endtask

  task automatic read(input int row, input logic clr);
    rd_req   = 1'b1;
    rd_row   = RW'(row);
    rd_clear = clr;
  endtask

  // One clock: inputs already set, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [DW-1:0] bank_of(input logic [NB*DW-1:0] d, input int b);
    return d[b*DW +: DW];
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    read(5, 1'b0);
    port_wr(0, 5, 0, 8'hEE);
    step();
    step();
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_vmask", rd_vmask, 0);
    check("reset_errs", {err_collide, err_badbank, rd_any, rd_first}, 0);
    rst = 1'b1;

    // Read of an empty row after reset.
    read(5, 1'b0);
    step();
    check("empty_rd_valid", rd_valid, 1);
    check("empty_vmask", rd_vmask, 0);
    check("empty_any_first", {rd_any, rd_first}, 0);
    check("empty_errs", {err_collide, err_badbank}, 0);
    step();
    check("rd_valid_drops", rd_valid, 0);

    // Basic write; same-cycle read sees pre-write state.
    port_wr(3, 7, 4, 8'hAB);
    read(7, 1'b0);
    step();
    check("rbw_vmask", rd_vmask, 0);
    read(7, 1'b0);
    step();
    check("basic_data", bank_of(rd_data, 4), 8'hAB);
    check("basic_vmask", rd_vmask, 10'h010);
    check("basic_first_any", {rd_any, rd_first}, {1'b1, 4'd4});
    step();
    check("hold_valid", rd_valid, 0);
    check("hold_vmask", rd_vmask, 10'h010);
    check("no_err_yet", {err_collide, err_badbank}, 0);

    // Collision: highest port wins.
    port_wr(1, 2, 0, 8'h11);
    port_wr(6, 2, 0, 8'h66);
    step();
    check("collide_flag", {err_collide, err_badbank}, 2'b10);
    read(2, 1'b0);
    step();
    check("collide_data", bank_of(rd_data, 0), 8'h66);
    check("collide_vmask", rd_vmask, 10'h001);
    check("collide_first_any", {rd_any, rd_first}, {1'b1, 4'd0});

    // Bad bank index writes nothing.
    port_wr(0, 3, 12, 8'h55);
    step();
    check("badbank_flags", {err_collide, err_badbank}, 2'b11);
    read(3, 1'b0);
    step();
    check("badbank_vmask", rd_vmask, 0);

    // Read-before-write with clear-on-retire.
    init_wen  = 1'b1;
    init_row  = 6'd9;
    init_mask = 10'h003;
    for (int b = 0; b < NB; b++) init_data[b*DW +: DW] = 8'(8'h90 + b);
    step();
    read(9, 1'b1);
    port_wr(2, 9, 5, 8'h5A);
    step();
    check("clr_vmask_pre", rd_vmask, 10'h003);
    check("clr_data_b1", bank_of(rd_data, 1), 8'h91);
    read(9, 1'b0);
    step();
    check("clr_vmask_post", rd_vmask, 10'h020);
    check("clr_first", rd_first, 4'd5);
    check("clr_data_b5", bank_of(rd_data, 5), 8'h5A);

    // Init and port write on the same cell: port wins.
    init_wen  = 1'b1;
    init_row  = 6'd10;
    init_mask = 10'h0F0;
    for (int b = 0; b < NB; b++) init_data[b*DW +: DW] = 8'(8'hC0 + b);
    port_wr(4, 10, 2, 8'h77);
    port_wr(5, 10, 4, 8'h44);
    step();
    read(10, 1'b0);
    step();
    check("init_vmask", rd_vmask, 10'h0F4);
    check("init_first", rd_first, 4'd2);
    check("init_data", {bank_of(rd_data, 2), bank_of(rd_data, 4), bank_of(rd_data, 6)},
          {8'h77, 8'h44, 8'hC6});

    // Flush overrides init; same-cycle read still sees pre-flush state.
    init_wen  = 1'b1;
    init_row  = 6'd1;
    init_mask = 10'h3FF;
    flush     = 1'b1;
    read(7, 1'b0);
    step();
    check("flush_pre_read", rd_vmask, 10'h010);
    read(1, 1'b0);
    step();
    check("flush_row1", {rd_any, rd_vmask}, 0);
    read(7, 1'b0);
    step();
    check("flush_row7", {rd_any, rd_vmask}, 0);
    check("flush_keeps_errs", {err_collide, err_badbank}, 2'b11);

    // Reset overrides a same-cycle read and write.
    rst = 1'b0;
    read(10, 1'b0);
    port_wr(0, 11, 1, 8'h01);
    step();
    check("rst2_outputs", {rd_valid, rd_any, rd_first, rd_vmask}, 0);
    check("rst2_errs", {err_collide, err_badbank}, 0);
    rst = 1'b1;
    read(11, 1'b0);
    step();
    check("rst2_no_write", rd_vmask, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
